packet_lock_arbiter: RTL and testbench

Per-output-port scheduler for the 5-port mesh router. It arbitrates among the five input ports (local, north, south, east, west) requesting one output port. It locks the output to the winner for a whole packet (FLITS_PER_PACKET flits) so packets from different inputs never interleave, and it stalls on downstream full. Its outputs drive the switch_matrix select, the input ports' stall (via grant) and the downstream write request.

---
 rtl/router_pkg.sv | 19 +
 rtl/packet_lock_arbiter_rr_pick.sv | 28 ++
 rtl/packet_lock_arbiter.sv | 136 +++++++++++++
 tb/tb_packet_lock_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router port indices, select encoding and arbiter state type
package router_pkg;

  localparam int NUM_PORTS = 5;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_SOUTH = 3'd2;
  localparam logic [2:0] PORT_EAST  = 3'd3;
  localparam logic [2:0] PORT_WEST  = 3'd4;

  localparam logic [2:0] SEL_NONE = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/packet_lock_arbiter_rr_pick.sv
// rtl/packet_lock_arbiter_rr_pick.sv - combinational 5-input rotating priority encoder (module rr_pick)
module rr_pick
  import router_pkg::*;
(
  input  logic [4:0] request,
  input  logic [2:0] ptr,
  output logic       valid,
  output logic [2:0] idx
);

  logic [3:0] pos;

  // walk offsets from farthest to nearest so the port closest to ptr is the last (winning) write
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    pos   = 4'd0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= 4'(NUM_PORTS)) pos = pos - 4'(NUM_PORTS);
      if (request[pos[2:0]]) begin
        valid = 1'b1;
        idx   = pos[2:0];
      end
    end
  end

endmodule

// File: rtl/packet_lock_arbiter.sv
// rtl/packet_lock_arbiter.sv - per-output packet-locking round-robin scheduler; optional watchdog via ARB_STALL_WATCHDOG_EN
module packet_lock_arbiter
  import router_pkg::*;
#(
  parameter int packet_size      = 32,
  parameter int flit_size        = 4,
  parameter int FLITS_PER_PACKET = packet_size / flit_size,
  parameter int STALL_LIMIT      = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] request,
  input  logic       destination_full,
  output logic [4:0] grant_vec,
  output logic [2:0] crossbar_control,
  output logic       write_request,
  output logic       busy
`ifdef ARB_STALL_WATCHDOG_EN
  ,
  output logic       stall_timeout
`endif
);

  // a single-flit packet still needs a 1-bit counter so the register has a legal width
  localparam int CNT_W = (FLITS_PER_PACKET > 1) ? $clog2(FLITS_PER_PACKET) : 1;
  localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(FLITS_PER_PACKET - 1);

  arb_state_t       state;
  logic [2:0]       owner;
  logic [2:0]       rr_ptr;
  logic [CNT_W-1:0] flit_cnt;
  logic             pick_valid;
  logic [2:0]       pick_idx;
  logic [7:0]       req_pad;
  logic             fire;

  rr_pick u_rr_pick (
    .request (request),
    .ptr     (rr_ptr),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // padding keeps the owner-indexed lookup in range for every 3-bit code
  assign req_pad       = {3'b000, request};
  assign fire          = (state == BUSY) && req_pad[owner] && !destination_full;
  assign write_request = fire;
  assign grant_vec     = fire ? (5'b00001 << owner) : 5'b00000;

  // lock the output to one input for a whole packet, then rotate priority past it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      owner            <= 3'd0;
      rr_ptr           <= 3'd0;
      flit_cnt         <= '0;
      crossbar_control <= SEL_NONE;
      busy             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state            <= BUSY;
            owner            <= pick_idx;
            flit_cnt         <= '0;
            crossbar_control <= pick_idx;
            busy             <= 1'b1;
          end
        end
        BUSY: begin
          if (fire) begin
            if (flit_cnt == LAST_FLIT) begin
              state            <= IDLE;
              flit_cnt         <= '0;
              rr_ptr           <= (owner == PORT_WEST) ? PORT_LOCAL : owner + 3'd1;
              crossbar_control <= SEL_NONE;
              busy             <= 1'b0;
            end else begin
              flit_cnt <= flit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STALL_WATCHDOG_EN
  localparam int SC_W = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_LIMIT);

  logic [SC_W-1:0] stall_cnt;
  logic [SC_W-1:0] stall_next;

  // consecutive blocked cycles while locked, saturating at the limit
  always_comb begin
    stall_next = stall_cnt;
    if ((state != BUSY) || fire) begin
      stall_next = '0;
    end else if (stall_cnt != STALL_MAX) begin
      stall_next = stall_cnt + SC_W'(1);
    end
  end

  // sticky timeout flag; observation only, arbitration never looks at it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      stall_cnt <= stall_next;
      if (stall_next == STALL_MAX) stall_timeout <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  logic [31:0] sim_cycles;

  // report the first timeout with the locked input and the cycle it happened
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sim_cycles <= 32'd0;
    end else begin
      sim_cycles <= sim_cycles + 32'd1;
      if ((stall_next == STALL_MAX) && !stall_timeout)
        $display("packet_lock_arbiter: stall timeout, crossbar_control=%0d cycle=%0d",
                 crossbar_control, sim_cycles);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_packet_lock_arbiter.sv
// tb/tb_packet_lock_arbiter.sv - randomized self-checking bench for packet_lock_arbiter against a packet-level model
module tb_packet_lock_arbiter;

  localparam int FPP = 8;

  logic       clk;
  logic       reset;
  logic [4:0] request;
  logic       destination_full;
  logic [4:0] grant_vec;
  logic [2:0] crossbar_control;
  logic       write_request;
  logic       busy;
`ifdef ARB_STALL_WATCHDOG_EN
  logic       stall_timeout;
`endif

  packet_lock_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .request          (request),
    .destination_full (destination_full),
    .grant_vec        (grant_vec),
    .crossbar_control (crossbar_control),
    .write_request    (write_request),
    .busy             (busy)
`ifdef ARB_STALL_WATCHDOG_EN
    ,
    .stall_timeout    (stall_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fires  = 0;

  // packet-level model: who holds the output, flits still owed, and who was served last
  int m_locked;
  int m_owner;
  int m_left;
  int m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_left   = 0;
    m_last   = 4;
  endtask

  function automatic int model_pick(input logic [4:0] r);
    for (int k = 1; k <= 5; k++) begin
      int p;
      p = (m_last + k) % 5;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  // compare the current cycle against the model, then advance the model across the clock edge
  task automatic step(input logic [4:0] req, input logic full);
    logic        exp_fire;
    logic [31:0] exp_grant;
    int          p;
    request          = req;
    destination_full = full;
    @(negedge clk);
    exp_fire  = (m_locked != 0) && req[m_owner] && !full;
    exp_grant = exp_fire ? (32'd1 << m_owner) : 32'd0;
    check("busy", 32'(busy), 32'(m_locked != 0));
    check("crossbar_control", 32'(crossbar_control), m_locked != 0 ? 32'(m_owner) : 32'd7);
    check("write_request", 32'(write_request), 32'(exp_fire));
    check("grant_vec", 32'(grant_vec), exp_grant);
    if (write_request) n_fires++;
    if (m_locked == 0) begin
      p = model_pick(req);
      if (p >= 0) begin
        m_locked = 1;
        m_owner  = p;
        m_left   = FPP;
      end
    end else if (exp_fire) begin
      m_left--;
      if (m_left == 0) begin
        m_locked = 0;
        m_last   = m_owner;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    request = 5'b0;
    destination_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_xc", 32'(crossbar_control), 32'd7);
    check("reset_wr", 32'(write_request), 32'd0);
    check("reset_grant", 32'(grant_vec), 32'd0);
`ifdef ARB_STALL_WATCHDOG_EN
    check("reset_timeout", 32'(stall_timeout), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int f0;
    logic [4:0] r;
    do_reset();

    // single local requester: one arbitration cycle, eight flits, back to idle
    f0 = n_fires;
    for (int i = 0; i < 10; i++) step(5'b00001, 1'b0);
    check("local_packet_flits", 32'(n_fires - f0), 32'd8);
    step(5'b00000, 1'b0);

    // north vs west from a fresh pointer, then alternate
    do_reset();
    for (int i = 0; i < 30; i++) step(5'b10010, 1'b0);

    // downstream full mid-packet while north owns the output
    do_reset();
    f0 = n_fires;
    step(5'b00010, 1'b0);
    for (int i = 0; i < 3; i++) step(5'b00010, 1'b0);
    for (int i = 0; i < 3; i++) step(5'b00010, 1'b1);
    for (int i = 0; i < 5; i++) step(5'b00010, 1'b0);
    check("full_resume_flits", 32'(n_fires - f0), 32'd8);
    step(5'b00000, 1'b0);

    // owner drops its request while local waits; lock must hold
    do_reset();
    step(5'b01000, 1'b0);
    for (int i = 0; i < 3; i++) step(5'b01000, 1'b0);
    for (int i = 0; i < 2; i++) step(5'b00001, 1'b0);
    for (int i = 0; i < 5; i++) step(5'b01001, 1'b0);
    for (int i = 0; i < 10; i++) step(5'b00001, 1'b0);

    // asynchronous reset in the middle of a packet
    do_reset();
    step(5'b00100, 1'b0);
    for (int i = 0; i < 4; i++) step(5'b00100, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_wr", 32'(write_request), 32'd0);
    check("async_xc", 32'(crossbar_control), 32'd7);
    check("async_grant", 32'(grant_vec), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    f0 = n_fires;
    for (int i = 0; i < 9; i++) step(5'b01000, 1'b0);
    check("post_reset_flits", 32'(n_fires - f0), 32'd8);

    // randomized traffic with occasional backpressure and bursty request changes
    r = 5'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 5'($urandom);
      step(r, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
